hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage MIPS core. It resolves the hazards that operand forwarding cannot cover by stalling and flushing: load-use stalls, taken-branch flushes and data-memory wait freezes. It drives the write-enable, flush and bubble controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also keeps saturating performance counters.

Parameters:
LOAD_STALLS, 1, bubble cycles inserted per load-use hazard (1..7)
CNT_W, 16, width of each performance counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
id_rs  input  5  rs field of the instruction in ID
id_rt  input  5  rt field of the instruction in ID
id_uses_rt  input  1  ID instruction reads rt as a source
ex_mem_read  input  1  instruction in EX is a load
ex_rt  input  5  destination register of the load in EX
branch_taken  input  1  branch/jump resolved taken in EX
mem_busy  input  1  data memory not ready; MEM stage must hold
cnt_clr  input  1  synchronous clear of all counters
pc_write  output  1  PC load enable
ifid_write  output  1  IF/ID load enable
ifid_flush  output  1  IF/ID loads a NOP
idex_write  output  1  ID/EX load enable
idex_bubble  output  1  ID/EX loads a NOP (control bits zeroed)
exmem_write  output  1  EX/MEM load enable
memwb_bubble  output  1  MEM/WB loads a NOP
stall_cnt  output  CNT_W  load-use bubble cycles
flush_cnt  output  CNT_W  branch flush events
freeze_cnt  output  CNT_W  mem_busy cycles

Behaviour:
- Load-use detect (combinational): lu = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
- FSM states: RUN and LSTALL. A 3-bit down-counter rem is used in LSTALL.
- Priority each cycle: mem_busy > branch_taken > stall (lu in RUN, or state LSTALL) > normal.
- FREEZE (mem_busy=1), any state:
  - pc_write=ifid_write=idex_write=exmem_write=0; memwb_bubble=1; all flush/bubble otherwise 0.
  - State and rem hold.
  - freeze_cnt increments.
  - branch_taken is ignored; it remains asserted because EX is held, and takes effect in the first cycle after mem_busy drops.
- FLUSH (branch_taken=1, mem_busy=0):
  - ifid_flush=1, idex_bubble=1, all write enables 1 (PC takes the target).
  - Next state RUN (aborts LSTALL); flush_cnt increments once per cycle.
- STALL (no mem_busy, no branch_taken, and lu=1 in RUN or state=LSTALL):
  - pc_write=0, ifid_write=0, idex_write=1, idex_bubble=1, exmem_write=1.
  - stall_cnt increments.
  - RUN with lu=1: if LOAD_STALLS=1, stay RUN; else go to LSTALL with rem=LOAD_STALLS-1.
  - LSTALL: rem decrements; on the stall cycle with rem=1, next state is RUN.
  - lu is not re-evaluated in LSTALL.
  - Total bubbles per hazard = LOAD_STALLS.
- NORMAL: all write enables 1; ifid_flush, idex_bubble, memwb_bubble 0.
- Counters:
  - Saturate at all-ones; no wrap.
  - cnt_clr has priority over increment; counters read 0 the cycle after cnt_clr.
- Reset:
  - rst_n low asynchronously forces state RUN, rem=0, all counters 0.
  - While rst_n is low, outputs show the NORMAL pattern regardless of inputs.
  - Reset mid-LSTALL abandons the remaining bubbles.
- ex_rt=0 never stalls. id_uses_rt=0 ignores a match on rt.
- Outputs are combinational from state and inputs; counters update on the rising clk edge.

Test Plan:
- Load-use, LOAD_STALLS=1: ex_mem_read=1, ex_rt=8, id_rs=8 -> one cycle of pc_write=0, ifid_write=0, idex_bubble=1; next cycle (load moved on) NORMAL; stall_cnt=1.
- LOAD_STALLS=3, ex_rt=9=id_rt, id_uses_rt=1 -> exactly 3 consecutive stall cycles, then NORMAL; stall_cnt=3. Repeat with id_uses_rt=0 -> no stall.
- Branch during stall: LOAD_STALLS=3, branch_taken=1 on 2nd bubble cycle -> that cycle ifid_flush=1, idex_bubble=1, pc_write=1; next cycle RUN/NORMAL; flush_cnt=1, stall_cnt=1.
- Freeze: mem_busy=1 for 4 cycles with branch_taken=1 -> all writes 0, memwb_bubble=1, no flush for 4 cycles; freeze_cnt=4; flush on the 5th cycle; flush_cnt=1.
- Counter saturation and clear: CNT_W=4 with 20 stall cycles -> stall_cnt=15; then cnt_clr=1 -> all counters 0 next cycle.
- Async reset: assert rst_n=0 mid-LSTALL between clock edges -> outputs NORMAL immediately, counters 0; after release, no residual bubbles.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and data-memory
// freezes for the 5-stage core, plus saturating event counters.
module hazard_ctrl #(
    parameter int unsigned LOAD_STALLS = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             branch_taken,
    input  logic             mem_busy,
    input  logic             cnt_clr,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_write,
    output logic             memwb_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    typedef enum logic [0:0] {StRun, StLstall} state_e;

    localparam logic [2:0]       RemInit = 3'(LOAD_STALLS - 1);
    localparam logic [CNT_W-1:0] CntMax  = '1;

    state_e     state_q, state_d;
    logic [2:0] rem_q, rem_d;

    logic lu;
    logic freeze;
    logic flush;
    logic stall;

    assign lu = ex_mem_read && (ex_rt != 5'd0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // Gating with rst_n makes the NORMAL pattern visible throughout reset.
    assign freeze = rst_n && mem_busy;
    assign flush  = rst_n && !mem_busy && branch_taken;
    assign stall  = rst_n && !mem_busy && !branch_taken && (lu || (state_q == StLstall));

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_write  = 1'b1;
        memwb_bubble = 1'b0;
        if (freeze) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
        end else if (flush) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (freeze) begin
            state_d = state_q;
            rem_d   = rem_q;
        end else if (flush) begin
            state_d = StRun;
            rem_d   = 3'd0;
        end else if (stall) begin
            if (state_q == StRun) begin
                if (LOAD_STALLS > 1) begin
                    state_d = StLstall;
                    rem_d   = RemInit;
                end
            end else begin
                // Bubble count is fixed at entry; lu is deliberately not rechecked here.
                rem_d = rem_q - 3'd1;
                if (rem_q == 3'd1) begin
                    state_d = StRun;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
            rem_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    function automatic logic [CNT_W-1:0] sat_next(input logic [CNT_W-1:0] cnt,
                                                 input logic clr, input logic inc);
        if (clr) begin
            return '0;
        end else if (inc && (cnt != CntMax)) begin
            return cnt + 1'b1;
        end
        return cnt;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            freeze_cnt <= '0;
        end else begin
            stall_cnt  <= sat_next(stall_cnt, cnt_clr, stall);
            flush_cnt  <= sat_next(flush_cnt, cnt_clr, flush);
            freeze_cnt <= sat_next(freeze_cnt, cnt_clr, freeze);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: one instance with LOAD_STALLS=1/CNT_W=16 and one with
// LOAD_STALLS=3/CNT_W=4 share the same stimulus and are checked side by side.
module tb_hazard_ctrl;

    // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, memwb_bubble}
    localparam logic [6:0] N = 7'b1101010;
    localparam logic [6:0] S = 7'b0001110;
    localparam logic [6:0] F = 7'b1111110;
    localparam logic [6:0] Z = 7'b0000001;

    typedef struct {
        logic       clr;
        logic       mr;
        logic [4:0] ert;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urt;
        logic       bt;
        logic       mb;
        logic [6:0] e1;
        logic [6:0] e3;
    } vec_t;

    typedef struct {
        logic [6:0] e1;
        logic [6:0] e3;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_mem_read, branch_taken, mem_busy, cnt_clr;

    logic        pcw1, ifw1, iff1, idw1, idb1, exw1, mwb1;
    logic        pcw3, ifw3, iff3, idw3, idb3, exw3, mwb3;
    logic [15:0] stall1, flush1, freeze1;
    logic [3:0]  stall3, flush3, freeze3;
    logic [6:0]  out1, out3;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    vec_t tbl[20];

    always #5 clk = ~clk;

    assign out1 = {pcw1, ifw1, iff1, idw1, idb1, exw1, mwb1};
    assign out3 = {pcw3, ifw3, iff3, idw3, idb3, exw3, mwb3};

    hazard_ctrl #(.LOAD_STALLS(1), .CNT_W(16)) u_ls1 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .cnt_clr(cnt_clr), .pc_write(pcw1), .ifid_write(ifw1),
        .ifid_flush(iff1), .idex_write(idw1), .idex_bubble(idb1), .exmem_write(exw1),
        .memwb_bubble(mwb1), .stall_cnt(stall1), .flush_cnt(flush1), .freeze_cnt(freeze1)
    );

    hazard_ctrl #(.LOAD_STALLS(3), .CNT_W(4)) u_ls3 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .cnt_clr(cnt_clr), .pc_write(pcw3), .ifid_write(ifw3),
        .ifid_flush(iff3), .idex_write(idw3), .idex_bubble(idb3), .exmem_write(exw3),
        .memwb_bubble(mwb3), .stall_cnt(stall3), .flush_cnt(flush3), .freeze_cnt(freeze3)
    );

    function automatic vec_t mk(logic mr, logic [4:0] ert, logic [4:0] rs, logic [4:0] rt,
                                logic urt, logic bt, logic mb, logic [6:0] e1, logic [6:0] e3);
        vec_t v;
        v.clr = 1'b0; v.mr = mr; v.ert = ert; v.rs = rs; v.rt = rt;
        v.urt = urt; v.bt = bt; v.mb = mb; v.e1 = e1; v.e3 = e3;
        return v;
    endfunction

    function automatic vec_t mkc(logic [6:0] e1, logic [6:0] e3);
        vec_t v;
        v = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, e1, e3);
        v.clr = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; outputs are compared at the following falling edge.
    task automatic step(input vec_t v, input string name);
        exp_t e;
        cnt_clr      = v.clr;
        ex_mem_read  = v.mr;
        ex_rt        = v.ert;
        id_rs        = v.rs;
        id_rt        = v.rt;
        id_uses_rt   = v.urt;
        branch_taken = v.bt;
        mem_busy     = v.mb;
        sb.push_back('{e1: v.e1, e3: v.e3});
        @(negedge clk);
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %0h/%0h", name, out1, out3);
        end else begin
            e = sb.pop_front();
            chk({name, "/ls1"}, 32'(out1), 32'(e.e1));
            chk({name, "/ls3"}, 32'(out3), 32'(e.e3));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, N, N);
        tbl[1]  = mk(1, 8, 8, 0, 0, 0, 0, S, S);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, N, S);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, N, S);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, N, N);
        tbl[5]  = mk(1, 0, 0, 0, 1, 0, 0, N, N);
        tbl[6]  = mk(1, 9, 3, 9, 0, 0, 0, N, N);
        tbl[7]  = mk(1, 9, 3, 9, 1, 0, 0, S, S);
        tbl[8]  = mk(0, 0, 0, 0, 0, 1, 0, F, F);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, N, N);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 1, Z, Z);
        tbl[11] = mk(0, 0, 0, 0, 0, 1, 1, Z, Z);
        tbl[12] = mk(0, 0, 0, 0, 0, 1, 0, F, F);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, N, N);
        tbl[14] = mk(1, 5, 5, 0, 0, 0, 1, Z, Z);
        tbl[15] = mk(1, 5, 5, 0, 0, 0, 0, S, S);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 1, Z, Z);
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, N, S);
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, N, S);
        tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, N, N);

        // Reset with hostile inputs: outputs must still read NORMAL.
        rst_n = 1'b0;
        cnt_clr = 1'b0; ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_rt = 5'd0;
        id_uses_rt = 1'b0; branch_taken = 1'b1; mem_busy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset/out1", 32'(out1), 32'(N));
        chk("reset/out3", 32'(out3), 32'(N));
        chk("reset/freeze1", 32'(freeze1), 32'd0);
        chk("reset/stall3", 32'(stall3), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_busy = 1'b0; branch_taken = 1'b0; ex_mem_read = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) begin
            step(tbl[i], $sformatf("row%0d", i));
        end

        // Load-use bubble counts per hazard.
        step(mkc(N, N), "lu/clr");
        chk("lu/clr_stall1", 32'(stall1), 32'd0);
        chk("lu/clr_flush1", 32'(flush1), 32'd0);
        chk("lu/clr_freeze3", 32'(freeze3), 32'd0);
        step(mk(1, 8, 8, 0, 0, 0, 0, S, S), "lu/c1");
        step(mk(0, 0, 0, 0, 0, 0, 0, N, S), "lu/c2");
        step(mk(0, 0, 0, 0, 0, 0, 0, N, S), "lu/c3");
        step(mk(0, 0, 0, 0, 0, 0, 0, N, N), "lu/c4");
        chk("lu/stall1", 32'(stall1), 32'd1);
        chk("lu/stall3", 32'(stall3), 32'd3);
        chk("lu/flush3", 32'(flush3), 32'd0);

        // Branch taken on the second bubble aborts the stall.
        step(mkc(N, N), "br/clr");
        step(mk(1, 9, 0, 9, 1, 0, 0, S, S), "br/c1");
        step(mk(0, 0, 0, 0, 0, 1, 0, F, F), "br/c2");
        step(mk(0, 0, 0, 0, 0, 0, 0, N, N), "br/c3");
        chk("br/stall3", 32'(stall3), 32'd1);
        chk("br/flush3", 32'(flush3), 32'd1);
        chk("br/flush1", 32'(flush1), 32'd1);

        // Freeze holds off a pending branch until mem_busy drops.
        step(mkc(N, N), "frz/clr");
        for (int i = 0; i < 4; i++) begin
            step(mk(0, 0, 0, 0, 0, 1, 1, Z, Z), $sformatf("frz/c%0d", i));
        end
        step(mk(0, 0, 0, 0, 0, 1, 0, F, F), "frz/flush");
        step(mk(0, 0, 0, 0, 0, 0, 0, N, N), "frz/after");
        chk("frz/freeze1", 32'(freeze1), 32'd4);
        chk("frz/freeze3", 32'(freeze3), 32'd4);
        chk("frz/flush3", 32'(flush3), 32'd1);

        // Saturation of the narrow counter, then clear.
        step(mkc(N, N), "sat/clr");
        for (int i = 0; i < 20; i++) begin
            step(mk(1, 8, 8, 0, 0, 0, 0, S, S), $sformatf("sat/c%0d", i));
        end
        chk("sat/stall3", 32'(stall3), 32'd15);
        chk("sat/stall1", 32'(stall1), 32'd20);
        step(mkc(N, S), "sat/clr2");
        chk("sat/clr_stall3", 32'(stall3), 32'd0);
        chk("sat/clr_stall1", 32'(stall1), 32'd0);
        chk("sat/clr_freeze1", 32'(freeze1), 32'd0);
        chk("sat/clr_flush3", 32'(flush3), 32'd0);
        step(mk(0, 0, 0, 0, 0, 0, 0, N, N), "sat/after");

        // Asynchronous reset in the middle of a multi-bubble stall.
        step(mk(1, 8, 8, 0, 0, 0, 0, S, S), "ar/lu");
        mem_busy = 1'b1; branch_taken = 1'b1; ex_mem_read = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar/out1", 32'(out1), 32'(N));
        chk("ar/out3", 32'(out3), 32'(N));
        chk("ar/stall1", 32'(stall1), 32'd0);
        chk("ar/stall3", 32'(stall3), 32'd0);
        @(negedge clk);
        mem_busy = 1'b0; branch_taken = 1'b0; ex_mem_read = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step(mk(0, 0, 0, 0, 0, 0, 0, N, N), "ar/post1");
        step(mk(0, 0, 0, 0, 0, 0, 0, N, N), "ar/post2");
        chk("ar/post_stall3", 32'(stall3), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
